// File: rtl/sha256_pkg.sv
// sha256_pkg: shared types, constants and helper functions for the SHA-256
// round engine.
//   state_t    : eight 32-bit working words, index 0 = A ... index 7 = H
//   eng_state_t: engine FSM states
//   K          : 64 round constants
//   H0         : standard initial hash value
//   rotr/ch/maj/big_sigma0/big_sigma1 : SHA-256 round primitives
package sha256_pkg;

    typedef logic [7:0][31:0] state_t;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_ROUND = 2'd1,
        S_FEED  = 2'd2,
        S_OUT   = 2'd3
    } eng_state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] H0 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 compression round.
//   st_i : working words A..H before the round
//   k_i  : round constant
//   w_i  : message schedule word
//   st_o : working words after the round
module sha256_round
    import sha256_pkg::*;
(
    input  state_t      st_i,
    input  logic [31:0] k_i,
    input  logic [31:0] w_i,
    output state_t      st_o
);

    logic [31:0] t1;
    logic [31:0] t2;

    always_comb begin
        t1 = st_i[7] + big_sigma1(st_i[4]) + ch(st_i[4], st_i[5], st_i[6]) + k_i + w_i;
        t2 = big_sigma0(st_i[0]) + maj(st_i[0], st_i[1], st_i[2]);

        st_o[0] = t1 + t2;
        st_o[1] = st_i[0];
        st_o[2] = st_i[1];
        st_o[3] = st_i[2];
        st_o[4] = st_i[3] + t1;
        st_o[5] = st_i[4];
        st_o[6] = st_i[5];
        st_o[7] = st_i[6];
    end

endmodule

// File: rtl/sha256_round_engine.sv
// sha256_round_engine: loads A..H serially, runs NUM_ROUNDS SHA-256 rounds
// (ROUNDS_PER_CYCLE per accepted schedule beat), optionally adds the loaded
// state back in, then streams A..H out with backpressure.
//   clk, reset          : clock, synchronous active-high reset
//   in_var/valid/ready  : state word load stream, order A..H
//   in_w/w_valid/ready  : schedule words, bits [31:0] = lowest round of group
//   out_var/valid/ready : result stream, order A..H; out_last marks H
//   busy                : low only when idle in LOAD with nothing loaded
module sha256_round_engine
    import sha256_pkg::*;
#(
    parameter int NUM_ROUNDS       = 64,
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int FEEDFORWARD      = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [31:0]                     in_var,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [32*ROUNDS_PER_CYCLE-1:0]  in_w,
    input  logic                            w_valid,
    output logic                            w_ready,
    output logic [31:0]                     out_var,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_last,
    output logic                            busy
);

    localparam int RPC = ROUNDS_PER_CYCLE;

    eng_state_t  state_q, state_d;
    // Shared word index: load slot in LOAD, output slot in OUT. It wraps to 0
    // after H in both, so OUT always starts at A and LOAD restarts at slot 0.
    logic [2:0]  idx_q, idx_d;
    logic [6:0]  round_q, round_d;
    state_t      work_q, work_d;
    state_t      init_q, init_d;

    state_t      chain [RPC+1];

    assign chain[0] = work_q;

    for (genvar g = 0; g < RPC; g++) begin : g_round
        logic [5:0] kidx;
        // round_q stays below 64 while rounds are being applied
        assign kidx = round_q[5:0] + 6'(g);

        sha256_round u_round (
            .st_i (chain[g]),
            .k_i  (K[kidx]),
            .w_i  (in_w[32*g +: 32]),
            .st_o (chain[g+1])
        );
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        round_d   = round_q;
        work_d    = work_q;
        init_d    = init_q;

        in_ready  = 1'b0;
        w_ready   = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_var   = '0;
        busy      = !((state_q == S_LOAD) && (idx_q == 3'd0));

        case (state_q)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    work_d[idx_q] = in_var;
                    init_d[idx_q] = in_var;
                    idx_d         = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_ROUND;
                        round_d = '0;
                    end
                end
            end
            S_ROUND: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    work_d  = chain[RPC];
                    round_d = round_q + 7'(RPC);
                    if (round_d == 7'(NUM_ROUNDS))
                        state_d = (FEEDFORWARD != 0) ? S_FEED : S_OUT;
                end
            end
            S_FEED: begin
                for (int i = 0; i < 8; i++)
                    work_d[i] = work_q[i] + init_q[i];
                state_d = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                out_var   = work_q[idx_q];
                out_last  = (idx_q == 3'd7);
                if (out_ready) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7)
                        state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_LOAD;
            idx_q   <= '0;
            round_q <= '0;
            work_q  <= '0;
            init_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            round_q <= round_d;
            work_q  <= work_d;
            init_q  <= init_d;
        end
    end

endmodule

// File: tb/tb_sha256_round_engine.sv
// Directed bench: four engine instances (1, 2, 4 rounds/cycle, and a
// single-round raw-output build) exercised one at a time on shared data buses.
module tb_sha256_round_engine;
    import sha256_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  in_var;
    logic [127:0] in_w;
    logic [3:0]   in_valid, in_ready, w_valid, w_ready;
    logic [3:0]   out_valid, out_ready, out_last, busy;
    logic [3:0][31:0] out_var;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;
    bit early_out;

    logic [31:0] wsrc [68];
    logic [31:0] iv  [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                             32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    logic [31:0] dig [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                             32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

    sha256_round_engine #(.NUM_ROUNDS(64), .ROUNDS_PER_CYCLE(1), .FEEDFORWARD(1)) u0 (
        .clk(clk), .reset(reset), .in_var(in_var), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_w(in_w[31:0]), .w_valid(w_valid[0]), .w_ready(w_ready[0]), .out_var(out_var[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_last(out_last[0]), .busy(busy[0]));

    sha256_round_engine #(.NUM_ROUNDS(64), .ROUNDS_PER_CYCLE(2), .FEEDFORWARD(1)) u1 (
        .clk(clk), .reset(reset), .in_var(in_var), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_w(in_w[63:0]), .w_valid(w_valid[1]), .w_ready(w_ready[1]), .out_var(out_var[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_last(out_last[1]), .busy(busy[1]));

    sha256_round_engine #(.NUM_ROUNDS(64), .ROUNDS_PER_CYCLE(4), .FEEDFORWARD(1)) u2 (
        .clk(clk), .reset(reset), .in_var(in_var), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_w(in_w), .w_valid(w_valid[2]), .w_ready(w_ready[2]), .out_var(out_var[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_last(out_last[2]), .busy(busy[2]));

    sha256_round_engine #(.NUM_ROUNDS(1), .ROUNDS_PER_CYCLE(1), .FEEDFORWARD(0)) u3 (
        .clk(clk), .reset(reset), .in_var(in_var), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .in_w(in_w[31:0]), .w_valid(w_valid[3]), .w_ready(w_ready[3]), .out_var(out_var[3]),
        .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_last(out_last[3]), .busy(busy[3]));

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic load_job(input int d, output int t_acc);
        int guard;
        t_acc = 0;
        for (int i = 0; i < 8; i++) begin
            guard = 0;
            @(negedge clk);
            in_valid[d] = 1'b1;
            in_var      = iv[i];
            while (!in_ready[d] && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) chk("load_timeout", 32'(guard), 32'd0);
            if (i == 0) t_acc = cyc;
            @(posedge clk);
        end
    endtask

    task automatic do_rounds(input int d, input int rpc, input int stop, input bit stall);
        int r = 0;
        int guard = 0;
        while (r < stop && guard < 1000) begin
            @(negedge clk);
            guard++;
            in_valid[d] = 1'b0;
            w_valid[d]  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            in_w        = {wsrc[r+3], wsrc[r+2], wsrc[r+1], wsrc[r]};
            if (out_valid[d]) early_out = 1'b1;
            if (w_valid[d] && w_ready[d]) r += rpc;
        end
        if (r < stop) chk("round_timeout", 32'(r), 32'(stop));
    endtask

    task automatic get_out(input int d, input bit drop3, input bit b2b,
                           output logic [7:0][31:0] res, output int t_out);
        int k = 0;
        int hold = 0;
        int guard = 0;
        t_out = -1;
        res   = '0;
        while (k < 8 && guard < 300) begin
            @(negedge clk);
            guard++;
            w_valid[d]   = 1'b0;
            out_ready[d] = !(drop3 && k == 3 && hold < 3);
            if (out_valid[d]) begin
                if (t_out < 0) t_out = cyc;
                if (out_ready[d]) begin
                    chk("out_last", 32'(out_last[d]), 32'(k == 7));
                    if (b2b && k == 7) begin
                        in_valid[d] = 1'b1;
                        in_var      = iv[0];
                        chk("b2b_blocked", 32'(in_ready[d]), 32'd0);
                    end
                    res[k] = out_var[d];
                    k++;
                end else begin
                    chk("stall_hold", out_var[d], dig[3]);
                    hold++;
                end
            end
        end
        chk("out_count", 32'(k), 32'd8);
        @(negedge clk);
        out_ready[d] = 1'b0;
        if (b2b) begin
            chk("b2b_ready", 32'(in_ready[d]), 32'd1);
            chk("b2b_idle", 32'(busy[d]), 32'd0);
            in_valid[d] = 1'b0;
        end else begin
            chk("out_done", 32'(out_valid[d]), 32'd0);
        end
    endtask

    task automatic chk_dig(input string tag, input logic [7:0][31:0] res);
        for (int i = 0; i < 8; i++) chk(tag, res[i], dig[i]);
    endtask

    task automatic chk_reset(input int d);
        chk("rst_in_ready", 32'(in_ready[d]), 32'd1);
        chk("rst_w_ready", 32'(w_ready[d]), 32'd0);
        chk("rst_out_valid", 32'(out_valid[d]), 32'd0);
        chk("rst_out_last", 32'(out_last[d]), 32'd0);
        chk("rst_out_var", out_var[d], 32'd0);
        chk("rst_busy", 32'(busy[d]), 32'd0);
    endtask

    logic [7:0][31:0] res;
    int ta, to;
    logic [31:0] s0, s1, t1, t2, m_a, m_e;

    initial begin
        reset = 1'b1; in_var = '0; in_w = '0;
        in_valid = '0; w_valid = '0; out_ready = '0; early_out = 1'b0;

        // "abc" single-block message schedule
        for (int t = 0; t < 68; t++) wsrc[t] = '0;
        wsrc[0]  = 32'h61626380;
        wsrc[15] = 32'h00000018;
        for (int t = 16; t < 64; t++) begin
            s0 = rr(wsrc[t-15], 7) ^ rr(wsrc[t-15], 18) ^ (wsrc[t-15] >> 3);
            s1 = rr(wsrc[t-2], 17) ^ rr(wsrc[t-2], 19) ^ (wsrc[t-2] >> 10);
            wsrc[t] = s1 + wsrc[t-7] + s0 + wsrc[t-16];
        end

        repeat (2) @(negedge clk);
        chk_reset(0);
        chk_reset(3);
        reset = 1'b0;

        // full "abc" compression, 1/2/4 rounds per cycle
        load_job(0, ta); do_rounds(0, 1, 64, 0); get_out(0, 0, 0, res, to);
        chk_dig("abc_rpc1", res); chk("lat_rpc1", 32'(to - ta), 32'd73);
        load_job(1, ta); do_rounds(1, 2, 64, 0); get_out(1, 0, 0, res, to);
        chk_dig("abc_rpc2", res); chk("lat_rpc2", 32'(to - ta), 32'd41);
        load_job(2, ta); do_rounds(2, 4, 64, 0); get_out(2, 0, 0, res, to);
        chk_dig("abc_rpc4", res); chk("lat_rpc4", 32'(to - ta), 32'd25);

        // random schedule stalls plus output backpressure on word D
        load_job(0, ta); do_rounds(0, 1, 64, 1); get_out(0, 1, 0, res, to);
        chk_dig("abc_stall", res);

        // single raw round with W = 02000000
        wsrc[0] = 32'h02000000;
        load_job(3, ta); do_rounds(3, 1, 1, 0); get_out(3, 0, 0, res, to);
        wsrc[0] = 32'h61626380;
        t1  = iv[7] + (rr(iv[4], 6) ^ rr(iv[4], 11) ^ rr(iv[4], 25))
            + ((iv[4] & iv[5]) ^ (~iv[4] & iv[6])) + K[0] + 32'h02000000;
        t2  = (rr(iv[0], 2) ^ rr(iv[0], 13) ^ rr(iv[0], 22))
            + ((iv[0] & iv[1]) ^ (iv[0] & iv[2]) ^ (iv[1] & iv[2]));
        m_a = t1 + t2;
        m_e = iv[3] + t1;
        chk("nr1_A", res[0], m_a);
        chk("nr1_B", res[1], 32'h6a09e667);
        chk("nr1_C", res[2], 32'hbb67ae85);
        chk("nr1_D", res[3], 32'h3c6ef372);
        chk("nr1_E", res[4], m_e);
        chk("nr1_F", res[5], 32'h510e527f);
        chk("nr1_G", res[6], 32'h9b05688c);
        chk("nr1_H", res[7], 32'h1f83d9ab);
        chk("lat_nr1", 32'(to - ta), 32'd9);

        // reset after 30 rounds, then a clean rerun
        early_out = 1'b0;
        load_job(0, ta); do_rounds(0, 1, 30, 0);
        @(negedge clk);
        w_valid[0] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk_reset(0);
        chk("rst_no_out", 32'(early_out), 32'd0);
        reset = 1'b0;
        load_job(0, ta); do_rounds(0, 1, 64, 0); get_out(0, 0, 0, res, to);
        chk_dig("abc_after_rst", res);

        // back-to-back jobs with in_valid raised during the last output beat
        load_job(0, ta); do_rounds(0, 1, 64, 0); get_out(0, 0, 1, res, to);
        chk_dig("abc_b2b_1", res);
        load_job(0, ta); do_rounds(0, 1, 64, 0); get_out(0, 0, 0, res, to);
        chk_dig("abc_b2b_2", res);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
